res_drain: RTL
==============

RES_DRAIN -- requirements
Module: res_drain

Interface
REQ-001 Parameter: M, default 3, array dimension (matrix is MxM).
REQ-002 Parameter: DW, default 16, result element width.
REQ-003 Port: CLK  input  1  sole clock; all state changes on its rising edge.
REQ-004 Port: rst  input  1  asynchronous, active-low reset.
REQ-005 Port: c  input  MxM x DW  result matrix, c[r][k] = row r, column k.
REQ-006 Port: c_vld  input  1  matrix on c is valid.
REQ-007 Port: c_rdy  output  1  block can capture a matrix this cycle.
REQ-008 Port: col_major  input  1  serialization order, sampled at capture; 0 = rows, 1 = columns.
REQ-009 Port: o_data  output  M x DW  one vector (row or column) of the captured matrix.
REQ-010 Port: o_idx  output  clog2(M) (min 1)  index of the vector on o_data.
REQ-011 Port: o_vld  output  1  o_data, o_idx and o_last are valid.
REQ-012 Port: o_rdy  input  1  downstream accepts the vector this cycle.
REQ-013 Port: o_last  output  1  o_data is vector M-1 of the current matrix.

Function
REQ-014 The block SHALL implement FSM states IDLE and DRAIN.
REQ-015 The block SHALL enter IDLE from reset; o_vld = 0, o_last = 0, o_idx = 0, o_data = 0 and c_rdy = 1 in IDLE.
REQ-016 The block SHALL capture c into an internal MxM register, latch col_major, set the index counter to 0 and go to DRAIN when c_vld && c_rdy.
REQ-017 In DRAIN, the block SHALL drive o_vld = 1, o_data = row idx of the captured matrix when the latched col_major = 0, and o_data = column idx (o_data[k] = buf[k][idx]) when col_major = 1.
REQ-018 The block SHALL hold o_data, o_idx and o_last stable while o_vld && !o_rdy; it SHALL NOT drop or skip any vector under backpressure.
REQ-019 On o_vld && o_rdy with idx < M-1, the block SHALL increment idx.
REQ-020 o_last SHALL equal (idx == M-1) while o_vld = 1.
REQ-021 On o_vld && o_rdy && o_last, the block SHALL return to IDLE, unless a new capture happens in the same cycle.
REQ-022 c_rdy SHALL be 1 in IDLE, and also in DRAIN during the cycle in which the last vector is accepted (o_rdy && o_last); it SHALL be 0 otherwise.
- This is a combinational path from o_rdy to c_rdy.
REQ-023 On a simultaneous last-vector handshake and capture, the block SHALL stay in DRAIN with the new matrix, idx = 0, and no idle bubble.
REQ-024 The block SHALL ignore changes on c and col_major outside a capture cycle.
REQ-025 Latency SHALL be one cycle from the capture edge to the first o_vld.
REQ-026 The block SHALL sustain one vector per cycle with o_rdy held at 1, i.e. M cycles per matrix back-to-back.
REQ-027 The data path SHALL pass elements unmodified at DW bits, with no arithmetic, truncation or sign change.
REQ-028 For M = 1, the block SHALL emit a single vector with o_last = 1.

Reset
REQ-029 Asserting rst low SHALL force IDLE, idx = 0, o_vld = 0, o_last = 0 and o_data = 0 immediately, regardless of CLK.
REQ-030 Reset during DRAIN SHALL abandon the current matrix; no further vectors of it appear after release.
REQ-031 c_rdy SHALL be 1 on the first cycle after reset deassertion.

Structure
REQ-032 Package mm_pkg SHALL hold the DW default, the FSM state enum (IDLE, DRAIN) and the index-width function.
REQ-033 The block SHALL be a single module with no sub-modules; the capture register and vector mux are inline.
REQ-034 The block SHALL connect directly to the systolic-array top-level outputs (c, vld_out to c_vld, rdy_out from c_rdy).

Verification (M=3, c = {{1,2,3},{4,5,6},{7,8,9}})
REQ-035 Row mode, o_rdy = 1 -> {1,2,3} idx 0, {4,5,6} idx 1, {7,8,9} idx 2 with o_last = 1, on three consecutive cycles; c_rdy is 1 in the last of those cycles.
REQ-036 col_major = 1 -> {1,4,7}, {2,5,8}, {3,6,9}; o_last only on {3,6,9}.
REQ-037 o_rdy low for 2 cycles while {4,5,6} is shown -> the vector is held unchanged, then {7,8,9} follows; no loss or duplication.
REQ-038 Back-to-back: second matrix of all 0x00AA presented with c_vld at the last handshake -> {0xAA,0xAA,0xAA} idx 0 on the next cycle, no bubble.
REQ-039 rst low after the idx 0 vector is accepted -> o_vld = 0 at once, then c_rdy = 1 after release, and a new capture restarts at idx 0.
REQ-040 c_vld with c_rdy = 0 (mid-drain) and c = 0xFFFF -> the in-flight output is unaffected and 0xFFFF never appears.

Source files
------------

// File: rtl/mm_pkg.sv
// Shared definitions for the matrix-multiply result path: default widths,
// drain FSM states and the index-width helper.
package mm_pkg;

    localparam int DW_DEFAULT = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    // An index port always needs at least one bit, even for a 1x1 matrix.
    function automatic int idx_width(input int m);
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/res_drain.sv
// Captures an MxM result matrix and serialises it as M row or column vectors
// over a valid/ready stream, accepting the next matrix on the last handshake.
module res_drain
    import mm_pkg::*;
#(
    parameter int M  = 3,
    parameter int DW = DW_DEFAULT,
    localparam int IW = idx_width(M)
) (
    input  logic                         CLK,
    input  logic                         rst,
    input  logic [M-1:0][M-1:0][DW-1:0]  c,
    input  logic                         c_vld,
    output logic                         c_rdy,
    input  logic                         col_major,
    output logic [M-1:0][DW-1:0]         o_data,
    output logic [IW-1:0]                o_idx,
    output logic                         o_vld,
    input  logic                         o_rdy,
    output logic                         o_last
);

    localparam logic [IW-1:0] LAST_IDX = IW'(M - 1);

    state_t                         state;
    state_t                         state_nxt;
    logic [M-1:0][M-1:0][DW-1:0]    mat_q;
    logic                           col_q;
    logic [IW-1:0]                  idx_q;
    logic                           at_last;
    logic                           last_hs;
    logic                           capture;

    // c_rdy opens during the final handshake so a new matrix can follow with no bubble.
    assign at_last = (state == DRAIN) && (idx_q == LAST_IDX);
    assign last_hs = at_last && o_rdy;
    assign c_rdy   = (state == IDLE) || last_hs;
    assign capture = c_vld && c_rdy;

    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (capture) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (last_hs) begin
                    state_nxt = capture ? DRAIN : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            mat_q <= '0;
            col_q <= 1'b0;
            idx_q <= '0;
        end else if (capture) begin
            mat_q <= c;
            col_q <= col_major;
            idx_q <= '0;
        end else if ((state == DRAIN) && o_rdy && !at_last) begin
            idx_q <= idx_q + 1'b1;
        end
    end

    // Column order transposes the read: element k of vector idx is mat[k][idx].
    always_comb begin
        o_vld  = 1'b0;
        o_last = 1'b0;
        o_idx  = '0;
        o_data = '0;
        if (state == DRAIN) begin
            o_vld  = 1'b1;
            o_last = at_last;
            o_idx  = idx_q;
            for (int k = 0; k < M; k++) begin
                o_data[k] = col_q ? mat_q[k][idx_q] : mat_q[idx_q][k];
            end
        end
    end

endmodule
